// File: rtl/ser_pkg.sv
// ser_pkg: shared state encoding and counter-width helper for the PISO serializer
package ser_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} ser_state_t;
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready word intake, LSB-first serial output with a last-bit flag
module piso_serializer
  import ser_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter int   GAP      = 0,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic             ser_out_o,
  output logic             last_o,
  output logic             busy_o
);
  localparam int CW = cnt_w(WIDTH);
  localparam int GW = cnt_w(GAP);
  ser_state_t       state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CW-1:0]    cnt_q;
  logic [GW-1:0]    gap_q;
  logic             ser_q, last_q, busy_q;
  logic             accept;
  // With GAP==0 the final bit's edge doubles as the next accept edge, so words stream without a bubble
  assign in_ready_o = (state_q == S_IDLE) || (state_q == S_SHIFT && cnt_q == '0 && GAP == 0);
  assign accept     = in_valid_i && in_ready_o;
  assign ser_out_o  = ser_q;
  assign last_o     = last_q;
  assign busy_o     = busy_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      ser_q   <= IDLE_LVL;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else if (accept) begin
      state_q <= S_SHIFT;
      ser_q   <= din_i[0];
      shreg_q <= din_i >> 1;
      cnt_q   <= CW'(WIDTH - 1);
      last_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        S_SHIFT: begin
          if (cnt_q != '0) begin
            ser_q   <= shreg_q[0];
            shreg_q <= shreg_q >> 1;
            cnt_q   <= cnt_q - 1'b1;
            last_q  <= (cnt_q == CW'(1));
          end else if (GAP > 0) begin
            state_q <= S_GAP;
            gap_q   <= GW'(GAP - 1);
            ser_q   <= IDLE_LVL;
            last_q  <= 1'b0;
          end else begin
            state_q <= S_IDLE;
            ser_q   <= IDLE_LVL;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        S_GAP: begin
          if (gap_q == '0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ser_q   <= IDLE_LVL;
          last_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule
